// File: rtl/chart_pkg.sv
// chart_pkg: shared state encoding, chart-word layout and default widths for chart_scheduler
package chart_pkg;
    localparam int DEF_ADDR_W      = 8;
    localparam int DEF_DELTA_W     = 8;
    localparam int DEF_LANE_W      = 2;
    localparam int DEF_CHART_DEPTH = 256;
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_WAIT_DATA = 3'd2,
        ST_COUNT     = 3'd3,
        ST_LAUNCH    = 3'd4,
        ST_DONE      = 3'd5
    } state_e;
    typedef struct packed {
        logic                   last;
        logic [DEF_LANE_W-1:0]  lane;
        logic [DEF_DELTA_W-1:0] delta;
    } chart_word_t;
endpackage

// File: rtl/chart_frame_timer.sv
// chart_frame_timer: loadable frame down-counter whose zero flag marks the frame that expires it
module chart_frame_timer #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);
    logic [W-1:0] count_q, count_d;
    // load wins over decrement; the count never wraps below zero
    always_comb count_d = load_i ? load_val_i : (dec_i && count_q != '0) ? count_q - W'(1) : count_q;
    // counter register
    always_ff @(posedge clk_i) count_q <= reset_i ? '0 : count_d;
    assign zero_o = dec_i && count_q == W'(1);
endmodule

// File: rtl/chart_scheduler.sv
// chart_scheduler: walks a rhythm chart, waits delta frames per word and hands each lane to the arrow lanes; CHART_PAUSE_EN adds pause_i
module chart_scheduler
    import chart_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DELTA_W     = DEF_DELTA_W,
    parameter int LANE_W      = DEF_LANE_W,
    parameter int CHART_DEPTH = DEF_CHART_DEPTH
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    frame_i,
    input  logic                    start_i,
    input  logic                    stop_i,
`ifdef CHART_PAUSE_EN
    input  logic                    pause_i,
`endif
    output logic                    rd_en_o,
    output logic [ADDR_W-1:0]       rd_addr_o,
    input  logic [LANE_W+DELTA_W:0] rd_data_i,
    output logic                    launch_valid_o,
    output logic [LANE_W-1:0]       lane_o,
    input  logic                    launch_ready_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [7:0]              late_cnt_o
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CHART_DEPTH - 1);
    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [LANE_W-1:0]  lane_q, lane_d;
    logic [7:0]         late_q, late_d;
    logic               frame_ok, word_end, tmr_load, tmr_dec, tmr_zero, last_word;
    logic [LANE_W-1:0]  word_lane;
    logic [DELTA_W-1:0] word_delta;
`ifdef CHART_PAUSE_EN
    assign frame_ok = frame_i & ~pause_i;
`else
    assign frame_ok = frame_i;
`endif
    assign {word_end, word_lane, word_delta} = rd_data_i;
    assign last_word = addr_q == LAST_ADDR;
    assign tmr_load  = state_q == ST_WAIT_DATA && !word_end && word_delta != '0;
    assign tmr_dec   = state_q == ST_COUNT && frame_ok;

    chart_frame_timer #(.W(DELTA_W)) u_timer (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .load_i     (tmr_load),
        .load_val_i (word_delta),
        .dec_i      (tmr_dec),
        .zero_o     (tmr_zero)
    );

    // sequencing: fetch a word, time it out in frames, hold the launch until accepted; stop freezes address and late count
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        lane_d  = lane_q;
        late_d  = late_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = start_i ? ST_FETCH : state_q;
                addr_d  = start_i ? '0 : addr_q;
                late_d  = start_i ? '0 : late_q;
            end
            ST_FETCH: state_d = ST_WAIT_DATA;
            ST_WAIT_DATA: begin
                lane_d  = word_lane;
                state_d = word_end ? ST_DONE : (word_delta == '0) ? ST_LAUNCH : ST_COUNT;
            end
            ST_COUNT: state_d = tmr_zero ? ST_LAUNCH : ST_COUNT;
            ST_LAUNCH: begin
                state_d = !launch_ready_i ? ST_LAUNCH : last_word ? ST_DONE : ST_FETCH;
                addr_d  = (launch_ready_i && !last_word) ? addr_q + ADDR_W'(1) : addr_q;
                late_d  = (!launch_ready_i && frame_ok && late_q != 8'hFF) ? late_q + 8'd1 : late_q;
            end
            default: state_d = ST_IDLE;
        endcase
        if (stop_i) begin
            state_d = ST_IDLE;
            addr_d  = addr_q;
            lane_d  = lane_q;
            late_d  = late_q;
        end
    end

    // state and datapath registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            lane_q  <= '0;
            late_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            lane_q  <= lane_d;
            late_q  <= late_d;
        end
    end

    assign rd_en_o        = state_q == ST_FETCH;
    assign rd_addr_o      = addr_q;
    assign launch_valid_o = state_q == ST_LAUNCH;
    assign lane_o         = lane_q;
    assign busy_o         = state_q inside {ST_FETCH, ST_WAIT_DATA, ST_COUNT, ST_LAUNCH};
    assign done_o         = state_q == ST_DONE;
    assign late_cnt_o     = late_q;
endmodule

// File: tb/tb_chart_scheduler.sv
// tb_chart_scheduler: table vectors, directed corner sequences and a randomized run against a timeline model
module tb_chart_scheduler;
    typedef struct packed {
        logic       last;
        logic [1:0] lane;
        logic [7:0] delta;
    } word_t;
    typedef struct {
        logic start, frame, ready;
        int   rd_en, addr, valid, lane, busy, done, late;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset_i, frame_i, start_i, stop_i, launch_ready_i;
`ifdef CHART_PAUSE_EN
    logic       pause_i;
`endif
    logic       rd_en, rd_en4, valid, valid4, busy, busy4, done, done4;
    logic [7:0] rd_addr, rd_addr4, late, late4;
    logic [10:0] rd_data, rd_data4;
    logic [1:0] lane, lane4;
    word_t      chart [0:255];
    word_t      chart4 [0:3];
    vec_t       tab [13];
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rd_en) rd_data <= chart[rd_addr];
        if (rd_en4) rd_data4 <= chart4[rd_addr4[1:0]];
    end

    chart_scheduler dut (
        .clk_i          (clk),
        .reset_i        (reset_i),
        .frame_i        (frame_i),
        .start_i        (start_i),
        .stop_i         (stop_i),
`ifdef CHART_PAUSE_EN
        .pause_i        (pause_i),
`endif
        .rd_en_o        (rd_en),
        .rd_addr_o      (rd_addr),
        .rd_data_i      (rd_data),
        .launch_valid_o (valid),
        .lane_o         (lane),
        .launch_ready_i (launch_ready_i),
        .busy_o         (busy),
        .done_o         (done),
        .late_cnt_o     (late)
    );

    chart_scheduler #(.CHART_DEPTH(4)) dut4 (
        .clk_i          (clk),
        .reset_i        (reset_i),
        .frame_i        (frame_i),
        .start_i        (start_i),
        .stop_i         (stop_i),
`ifdef CHART_PAUSE_EN
        .pause_i        (pause_i),
`endif
        .rd_en_o        (rd_en4),
        .rd_addr_o      (rd_addr4),
        .rd_data_i      (rd_data4),
        .launch_valid_o (valid4),
        .lane_o         (lane4),
        .launch_ready_i (launch_ready_i),
        .busy_o         (busy4),
        .done_o         (done4),
        .late_cnt_o     (late4)
    );

    function automatic word_t w(input int l, input int ln, input int d);
        return {1'(l), 2'(ln), 8'(d)};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic f, input logic r, input logic p);
        start_i        = s;
        frame_i        = f;
        launch_ready_i = r;
        stop_i         = p;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_i = 1'b1;
        drive(0, 0, 0, 0);
        @(negedge clk);
        reset_i = 1'b0;
    endtask

    task automatic clear_chart();
        for (int i = 0; i < 256; i++) chart[i] = w(1, 0, 0);
    endtask

    // expected behaviour expressed as a timeline: fetch cycle, frames still owed, launch pending
    task automatic run_random();
        int c, fetch_at, left, k, mlate;
        bit m_idle, m_done, m_launch, s, f, r;
        clear_chart();
        for (int i = 0; i < 10; i++) chart[i] = w(0, $urandom_range(3), $urandom_range(3));
        do_reset();
        m_idle = 1; m_done = 0; m_launch = 0; fetch_at = -10; left = 0; k = 0; mlate = 0;
        for (c = 0; c < 3000; c++) begin
            chk("rnd_rd_en", int'(rd_en), int'(!m_idle && !m_done && c == fetch_at));
            if (rd_en) chk("rnd_addr", int'(rd_addr), k);
            chk("rnd_valid", int'(valid), int'(m_launch));
            if (m_launch) chk("rnd_lane", int'(lane), int'(chart[k].lane));
            chk("rnd_busy", int'(busy), int'(!m_idle && !m_done));
            chk("rnd_done", int'(done), int'(m_done));
            chk("rnd_late", int'(late), mlate);
            if (m_done) break;
            s = (c == 0);
            f = ($urandom_range(2) == 0);
            r = 1'($urandom_range(1));
            drive(s, f, r, 0);
            if (s) begin
                m_idle = 0; fetch_at = 1; mlate = 0; k = 0;
            end else if (m_launch) begin
                if (r) begin
                    m_launch = 0; k++; fetch_at = c + 1;
                end else if (f && mlate < 255) mlate++;
            end else if (!m_idle && !m_done) begin
                if (c == fetch_at + 1) begin
                    if (chart[k].last) m_done = 1;
                    else if (chart[k].delta == 0) m_launch = 1;
                    else left = int'(chart[k].delta);
                end else if (c >= fetch_at + 2 && f) begin
                    left--;
                    if (left == 0) m_launch = 1;
                end
            end
            @(negedge clk);
        end
        chk("rnd_finished", int'(done), 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        int acc;
`ifdef CHART_PAUSE_EN
        pause_i = 1'b0;
`endif
        reset_i = 1'b1;
        drive(0, 0, 0, 0);
        clear_chart();
        for (int i = 0; i < 4; i++) chart4[i] = w(0, i, i % 2);
        repeat (2) @(negedge clk);
        chk("rst_rd_en", int'(rd_en), 0);
        chk("rst_addr", int'(rd_addr), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_lane", int'(lane), 0);
        chk("rst_late", int'(late), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        reset_i = 1'b0;

        // two-word chart: lane 1 after three frames, then the end word
        chart[0] = w(0, 1, 3);
        chart[1] = w(1, 0, 0);
        tab = '{
            '{1'b1, 1'b0, 1'b0, 0, 0, 0, -1, 0, 0, 0},
            '{1'b0, 1'b0, 1'b0, 1, 0, 0, -1, 1, 0, 0},
            '{1'b0, 1'b1, 1'b0, 0, 0, 0, -1, 1, 0, 0},
            '{1'b0, 1'b1, 1'b0, 0, 0, 0, -1, 1, 0, 0},
            '{1'b1, 1'b0, 1'b0, 0, 0, 0, -1, 1, 0, 0},
            '{1'b0, 1'b1, 1'b0, 0, 0, 0, -1, 1, 0, 0},
            '{1'b0, 1'b1, 1'b0, 0, 0, 0, -1, 1, 0, 0},
            '{1'b0, 1'b1, 1'b0, 0, 0, 1, 1, 1, 0, 0},
            '{1'b0, 1'b1, 1'b1, 0, 0, 1, 1, 1, 0, 1},
            '{1'b0, 1'b0, 1'b0, 1, 1, 0, -1, 1, 0, 1},
            '{1'b0, 1'b1, 1'b0, 0, 1, 0, -1, 1, 0, 1},
            '{1'b0, 1'b1, 1'b0, 0, 1, 0, -1, 0, 1, 1},
            '{1'b0, 1'b0, 1'b0, 0, 1, 0, -1, 0, 1, 1}
        };
        do_reset();
        for (int i = 0; i < 13; i++) begin
            chk($sformatf("tab%0d_rd_en", i), int'(rd_en), tab[i].rd_en);
            chk($sformatf("tab%0d_addr", i), int'(rd_addr), tab[i].addr);
            chk($sformatf("tab%0d_valid", i), int'(valid), tab[i].valid);
            if (tab[i].lane >= 0) chk($sformatf("tab%0d_lane", i), int'(lane), tab[i].lane);
            chk($sformatf("tab%0d_busy", i), int'(busy), tab[i].busy);
            chk($sformatf("tab%0d_done", i), int'(done), tab[i].done);
            chk($sformatf("tab%0d_late", i), int'(late), tab[i].late);
            drive(tab[i].start, tab[i].frame, tab[i].ready, 1'b0);
            @(negedge clk);
        end

        // zero-delta word launches two cycles after its read; reset then drops the launch
        clear_chart();
        chart[0] = w(0, 2, 0);
        do_reset();
        drive(1, 0, 0, 0);
        @(negedge clk);
        drive(0, 0, 0, 0);
        chk("z_rd_en", int'(rd_en), 1);
        @(negedge clk);
        chk("z_wait_valid", int'(valid), 0);
        @(negedge clk);
        chk("z_valid", int'(valid), 1);
        chk("z_lane", int'(lane), 2);
        drive(0, 1, 0, 0);
        @(negedge clk);
        chk("z_late", int'(late), 1);
        reset_i = 1'b1;
        drive(0, 0, 1, 0);
        @(negedge clk);
        reset_i = 1'b0;
        chk("rs_valid", int'(valid), 0);
        chk("rs_lane", int'(lane), 0);
        chk("rs_late", int'(late), 0);
        chk("rs_busy", int'(busy), 0);
        repeat (2) @(negedge clk);
        chk("rs_idle_busy", int'(busy), 0);
        chk("rs_idle_addr", int'(rd_addr), 0);

        // lane held with ready low: late count saturates
        clear_chart();
        chart[0] = w(0, 3, 1);
        do_reset();
        drive(1, 0, 0, 0);
        @(negedge clk);
        drive(0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        chk("sat_count_valid", int'(valid), 0);
        drive(0, 1, 0, 0);
        @(negedge clk);
        chk("sat_valid", int'(valid), 1);
        chk("sat_late0", int'(late), 0);
        for (int i = 0; i < 300; i++) begin
            drive(0, 1, 0, 0);
            @(negedge clk);
            chk("sat_lane", int'(lane), 3);
            chk("sat_hold", int'(valid), 1);
        end
        chk("sat_late", int'(late), 255);
        drive(0, 0, 1, 0);
        @(negedge clk);
        drive(0, 0, 0, 0);
        chk("sat_acc_valid", int'(valid), 0);
        chk("sat_acc_rd_en", int'(rd_en), 1);
        chk("sat_acc_addr", int'(rd_addr), 1);
        @(negedge clk);
        @(negedge clk);
        chk("sat_done", int'(done), 1);
        chk("sat_late_kept", int'(late), 255);

        // stop mid-count, then a fresh start reads address 0 and times the full delta again
        clear_chart();
        chart[0] = w(0, 1, 5);
        do_reset();
        drive(1, 0, 0, 0);
        @(negedge clk);
        drive(0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        drive(0, 1, 0, 0);
        repeat (3) @(negedge clk);
        chk("stop_pre_busy", int'(busy), 1);
        chk("stop_pre_valid", int'(valid), 0);
        drive(1, 1, 1, 1);
        @(negedge clk);
        chk("stop_busy", int'(busy), 0);
        chk("stop_valid", int'(valid), 0);
        chk("stop_done", int'(done), 0);
        chk("stop_rd_en", int'(rd_en), 0);
        drive(0, 1, 0, 0);
        @(negedge clk);
        chk("stop_idle", int'(busy), 0);
        drive(1, 0, 0, 0);
        @(negedge clk);
        drive(0, 0, 0, 0);
        chk("restart_rd_en", int'(rd_en), 1);
        chk("restart_addr", int'(rd_addr), 0);
        @(negedge clk);
        @(negedge clk);
        drive(0, 1, 0, 0);
        repeat (4) @(negedge clk);
        chk("restart_early", int'(valid), 0);
        @(negedge clk);
        chk("restart_valid", int'(valid), 1);
        chk("restart_lane", int'(lane), 1);

        // four-word chart without an end word stops after its last address
        do_reset();
        drive(1, 1, 1, 0);
        @(negedge clk);
        drive(0, 1, 1, 0);
        acc = 0;
        for (int t = 0; t < 60 && !done4; t++) begin
            if (valid4) begin
                chk("d4_lane", int'(lane4), acc);
                acc++;
            end
            @(negedge clk);
        end
        chk("d4_done", int'(done4), 1);
        chk("d4_accepts", acc, 4);
        chk("d4_addr", int'(rd_addr4), 3);
        repeat (5) @(negedge clk);
        chk("d4_still_done", int'(done4), 1);
        chk("d4_no_wrap", int'(rd_addr4), 3);
        chk("d4_busy", int'(busy4), 0);
        chk("d4_late", int'(late4), 0);

`ifdef CHART_PAUSE_EN
        // paused frames do not count toward the delta
        clear_chart();
        chart[0] = w(0, 1, 2);
        do_reset();
        drive(1, 0, 0, 0);
        @(negedge clk);
        drive(0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        pause_i = 1'b1;
        drive(0, 1, 0, 0);
        repeat (5) begin
            @(negedge clk);
            chk("pause_hold", int'(valid), 0);
        end
        pause_i = 1'b0;
        @(negedge clk);
        chk("pause_one_left", int'(valid), 0);
        @(negedge clk);
        chk("pause_valid", int'(valid), 1);
        chk("pause_lane", int'(lane), 1);
`endif

        repeat (3) run_random();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/chart_scheduler.md
CHART_SCHEDULER -- requirements
Module: chart_scheduler

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, chart address width.
REQ-002 SHALL have parameter DELTA_W, default 8, frame-delta field width.
REQ-003 SHALL have parameter LANE_W, default 2, lane field width.
REQ-004 SHALL have parameter CHART_DEPTH, default 256, number of chart words.
REQ-005 SHALL have port clk_i  in  1  sole clock; reset_i  in  1  synchronous active-high reset.
REQ-006 SHALL have port frame_i  in  1  one-cycle frame strobe.
REQ-007 SHALL have port start_i  in  1  start or restart song; stop_i  in  1  abort to idle.
REQ-008 SHALL have port rd_en_o  out  1  chart read strobe; rd_addr_o  out  ADDR_W  chart address.
REQ-009 SHALL have port rd_data_i  in  1+LANE_W+DELTA_W  chart word, valid exactly 1 cycle after rd_en_o; layout {end, lane, delta}.
REQ-010 SHALL have port launch_valid_o  out  1; lane_o  out  LANE_W; launch_ready_i  in  1  (launch handshake to arrow lanes).
REQ-011 SHALL have port busy_o  out  1  song in progress; done_o  out  1  song finished; late_cnt_o  out  8  late-launch frame count.

Function
REQ-012 SHALL implement states IDLE, FETCH, WAIT_DATA, COUNT, LAUNCH, DONE.
REQ-013 IDLE/DONE: start_i -> FETCH with rd_addr_o=0 and late_cnt_o cleared; start_i ignored in all other states.
REQ-014 FETCH: rd_en_o high for exactly that cycle -> WAIT_DATA.
REQ-015 WAIT_DATA: latch rd_data_i; end=1 -> DONE; end=0, delta=0 -> LAUNCH; otherwise load frame timer with delta -> COUNT.
REQ-016 COUNT: each frame_i decrements timer; the frame_i that takes timer to 0 -> LAUNCH on next cycle.
REQ-017 frame_i in IDLE, FETCH, WAIT_DATA, DONE SHALL be ignored; delta is measured from the cycle after handshake acceptance.
REQ-018 LAUNCH: launch_valid_o=1, lane_o=latched lane, both stable until launch_valid_o & launch_ready_i.
REQ-019 On accept: if rd_addr_o==CHART_DEPTH-1 -> DONE, else rd_addr_o+1 -> FETCH.
REQ-020 In LAUNCH with launch_ready_i=0, each frame_i SHALL increment late_cnt_o, saturating at 255.
REQ-021 launch_valid_o SHALL never be high outside LAUNCH; at most one accept per chart word.
REQ-022 busy_o=1 in FETCH, WAIT_DATA, COUNT, LAUNCH; done_o=1 only in DONE.
REQ-023 stop_i SHALL force IDLE on next cycle from any state, overriding all other inputs; rd_addr_o and late_cnt_o retain value.
REQ-024 frame_i coincident with accept in LAUNCH SHALL not count toward the next delta or late_cnt_o.

Reset
REQ-025 reset_i SHALL override stop_i and start_i, forcing IDLE, rd_addr_o=0, rd_en_o=0, launch_valid_o=0, lane_o=0, late_cnt_o=0, timer=0, busy_o=0, done_o=0.
REQ-026 reset_i mid-song SHALL drop launch_valid_o the following cycle with no accept recorded.

Configuration
REQ-027 With CHART_PAUSE_EN defined: port pause_i in 1; while high, frame_i ignored in COUNT and for late_cnt_o; FSM and handshake otherwise unaffected.
REQ-028 Without CHART_PAUSE_EN: no pause_i port; frame_i always honoured per REQ-016/REQ-020.

Structure
REQ-029 Package chart_pkg SHALL hold the state enum, the chart-word struct {end, lane, delta}, and default width constants.
REQ-030 Frame down-counter SHALL be sub-module chart_frame_timer (load, dec-on-frame, zero flag).

Verification
REQ-031 Chart {0,lane1,3},{1,0,0}; start; 3 frame_i -> launch_valid_o with lane_o=1 one cycle after 3rd frame; after accept -> DONE, done_o=1.
REQ-032 Word {0,lane2,0} -> launch_valid_o two cycles after rd_en_o, zero frames waited.
REQ-033 launch_ready_i held low for 300 frames in LAUNCH -> late_cnt_o saturates at 255, lane_o stable throughout.
REQ-034 stop_i during COUNT with 2 frames left -> IDLE next cycle, launch_valid_o=0; start_i -> fetch resumes at addr 0.
REQ-035 CHART_DEPTH=4, no end word -> exactly 4 accepts, then DONE; rd_addr_o=3, no wrap.
REQ-036 CHART_PAUSE_EN defined, delta=2, pause_i high over 5 frames then low -> launch only after 2 further unpaused frames.
